// File: rtl/dbus_interconnect_pkg.sv
// Shared types for the data-bus interconnect: FSM states, error codes and
// the default read data returned for an errored access.
package dbus_interconnect_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNMAPPED = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } err_code_t;

  localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/dbus_interconnect_if.sv
// Bundle of CPU-side, slave-side and error-report signals of the interconnect.
// The master modport is the environment view; slave is the interconnect view.
interface dbus_interconnect_if #(
  parameter int NSLV = 8,
  parameter int DW   = 32
);
  logic                 m_stb;
  logic [DW/8-1:0]      m_we;
  logic [31:0]          m_addr;
  logic [DW-1:0]        m_wdata;
  logic [DW-1:0]        m_rdata;
  logic                 m_nak;
  logic [NSLV-1:0]      s_en;
  logic [DW/8-1:0]      s_we;
  logic [31:0]          s_addr;
  logic [DW-1:0]        s_wdata;
  logic [NSLV*DW-1:0]   s_rdata;
  logic [NSLV-1:0]      s_nak;
  logic                 err_clr;
  logic                 err_irq;
  logic [31:0]          err_addr;
  logic [1:0]           err_code;

  modport master (
    output m_stb, m_we, m_addr, m_wdata, s_rdata, s_nak, err_clr,
    input  m_rdata, m_nak, s_en, s_we, s_addr, s_wdata, err_irq, err_addr, err_code
  );

  modport slave (
    input  m_stb, m_we, m_addr, m_wdata, s_rdata, s_nak, err_clr,
    output m_rdata, m_nak, s_en, s_we, s_addr, s_wdata, err_irq, err_addr, err_code
  );

endinterface

// File: rtl/dbus_interconnect_addr_decoder.sv
// Region decoder: compares the address select field against each enabled
// slave's region code; the lowest-numbered matching slave wins.
module dbus_interconnect_addr_decoder #(
  parameter int                     NSLV      = 8,
  parameter int                     SELW      = 4,
  parameter int                     IW        = 3,
  parameter logic [NSLV*SELW-1:0]   SLV_MAP   = '1,
  parameter logic [NSLV-1:0]        SLV_VALID = '0
) (
  input  logic [SELW-1:0] i_sel,
  output logic [IW-1:0]   o_idx,
  output logic            o_hit_any
);

  logic [NSLV-1:0] w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NSLV; gi++) begin : g_hit
      assign w_hit[gi] = SLV_VALID[gi] && (i_sel == SLV_MAP[gi*SELW +: SELW]);
    end
  endgenerate

  // Scan from the top down so the lowest matching index is left last.
  always_comb begin
    o_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (w_hit[i]) o_idx = IW'(i);
    end
  end

  assign o_hit_any = |w_hit;

endmodule

// File: rtl/dbus_interconnect.sv
// CPU data-port interconnect to NSLV slaves with wait-state stalling, a
// timeout watchdog and a sticky bus-error report.
module dbus_interconnect
  import dbus_interconnect_pkg::*;
#(
  parameter int                                  NSLV      = 8,
  parameter int                                  DW        = 32,
  parameter int                                  SEL_HI    = 31,
  parameter int                                  SEL_LO    = 28,
  parameter logic [NSLV*(SEL_HI-SEL_LO+1)-1:0]   SLV_MAP   = {8{4'hF}},
  parameter logic [NSLV-1:0]                     SLV_VALID = '0,
  parameter int                                  TIMEOUT   = 255,
  parameter logic [DW-1:0]                       ERR_DATA  = DW'(DEF_ERR_DATA)
) (
  input  logic               clk,
  input  logic               rstn,
  dbus_interconnect_if.slave bus
);

  localparam int SELW = SEL_HI - SEL_LO + 1;
  localparam int IW   = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW   = $clog2(TIMEOUT + 1);

  logic [IW-1:0] w_idx;
  logic          w_hit_any;

  dbus_interconnect_addr_decoder #(
    .NSLV      (NSLV),
    .SELW      (SELW),
    .IW        (IW),
    .SLV_MAP   (SLV_MAP),
    .SLV_VALID (SLV_VALID)
  ) u_decoder (
    .i_sel     (bus.m_addr[SEL_HI:SEL_LO]),
    .o_idx     (w_idx),
    .o_hit_any (w_hit_any)
  );

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_wait_cnt, w_wait_cnt_next;
  logic [IW-1:0] r_wait_idx, w_wait_idx_next;
  logic          r_sel_vld, r_sel_err;
  logic [IW-1:0] r_sel_idx;
  logic          r_err_irq;
  logic [31:0]   r_err_addr;
  err_code_t     r_err_code;

  logic w_force_done, w_nak, w_done, w_err_evt, w_go;

  assign w_force_done = (r_state == ST_WAIT) && (r_wait_cnt == CW'(TIMEOUT));
  // Gating with rstn makes the combinational outputs idle as soon as reset asserts.
  assign w_go      = rstn && bus.m_stb && w_hit_any && !w_force_done;
  assign w_nak     = w_go && bus.s_nak[w_idx];
  assign w_done    = bus.m_stb && !w_nak;
  assign w_err_evt = w_done && (!w_hit_any || w_force_done);

  assign bus.m_nak   = w_nak;
  assign bus.s_en    = w_go ? (NSLV'(1) << w_idx) : '0;
  assign bus.s_we    = w_go ? bus.m_we : '0;
  assign bus.s_addr  = bus.m_addr;
  assign bus.s_wdata = bus.m_wdata;
  assign bus.m_rdata = !r_sel_vld ? '0 :
                       r_sel_err  ? ERR_DATA : bus.s_rdata[r_sel_idx*DW +: DW];

  assign bus.err_irq  = r_err_irq;
  assign bus.err_addr = r_err_addr;
  assign bus.err_code = r_err_code;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_wait_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_wait_idx <= w_wait_idx_next;
    end
  end

  // Any cycle without a stall ends the wait: completion, timeout or strobe drop.
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_wait_idx_next = r_wait_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_nak) begin
          w_state_next    = ST_WAIT;
          w_wait_cnt_next = CW'(1);
          w_wait_idx_next = w_idx;
        end
      end
      ST_WAIT: begin
        if (!w_nak) begin
          w_state_next    = ST_IDLE;
          w_wait_cnt_next = '0;
        end else if (w_idx != r_wait_idx) begin
          w_wait_cnt_next = CW'(1);
          w_wait_idx_next = w_idx;
        end else if (r_wait_cnt != CW'(TIMEOUT)) begin
          w_wait_cnt_next = r_wait_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next    = ST_IDLE;
        w_wait_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sel_vld  <= 1'b0;
      r_sel_err  <= 1'b0;
      r_sel_idx  <= '0;
      r_err_irq  <= 1'b0;
      r_err_addr <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      if (w_done) begin
        r_sel_vld <= 1'b1;
        r_sel_err <= !w_hit_any || w_force_done;
        r_sel_idx <= w_idx;
      end
      // A new error beats a simultaneous clear; otherwise the first error sticks.
      if (w_err_evt && (!r_err_irq || bus.err_clr)) begin
        r_err_irq  <= 1'b1;
        r_err_addr <= bus.m_addr;
        r_err_code <= w_force_done ? ERR_TIMEOUT : ERR_UNMAPPED;
      end else if (bus.err_clr) begin
        r_err_irq  <= 1'b0;
        r_err_addr <= '0;
        r_err_code <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_dbus_interconnect.sv
// Directed bench for dbus_interconnect: a per-cycle reference model of the
// bus rules plus literal expectations at the key points of each scenario.
module tb_dbus_interconnect;

  localparam int          NSLV = 4;
  localparam int          DW   = 32;
  localparam int          TMO  = 4;
  localparam logic [15:0] MAP  = {4'h3, 4'hA, 4'h2, 4'h1};
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dbus_interconnect_if #(.NSLV(NSLV), .DW(DW)) bus ();

  dbus_interconnect #(
    .NSLV      (NSLV),
    .DW        (DW),
    .SEL_HI    (31),
    .SEL_LO    (28),
    .SLV_MAP   (MAP),
    .SLV_VALID (4'hF),
    .TIMEOUT   (TMO),
    .ERR_DATA  (ERRD)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %08h required %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Region table of the bench's own address map (slave i -> top nibble).
  logic [3:0] region [NSLV] = '{4'h1, 4'h2, 4'hA, 4'h3};

  function automatic int slave_of(input logic [31:0] a);
    for (int i = 0; i < NSLV; i++) begin
      if (a[31:28] == region[i]) return i;
    end
    return -1;
  endfunction

  // Reference model state: consecutive stalls on the current slave, who
  // answered the last completed access (-2 none, -1 error), and the error latch.
  int          stall_n   = 0;
  int          stall_slv = -1;
  int          last      = -2;
  bit          e_irq     = 1'b0;
  logic [31:0] e_addr    = '0;
  logic [1:0]  e_code    = 2'b00;

  initial begin : compare
    int          sl;
    bit          forced, stall, done, err;
    logic [3:0]  en, we;
    logic [31:0] rd;
    forever begin
      @(negedge clk);
      #4;
      if (!rstn) begin
        stall_n = 0; stall_slv = -1; last = -2;
        e_irq = 1'b0; e_addr = '0; e_code = 2'b00;
      end
      sl     = slave_of(bus.m_addr);
      forced = (stall_n >= TMO);
      stall  = rstn && bus.m_stb && (sl >= 0) && bus.s_nak[sl] && !forced;
      en     = (rstn && bus.m_stb && (sl >= 0) && !forced) ? (4'b0001 << sl) : 4'b0000;
      we     = (en != 0) ? bus.m_we : 4'b0000;
      if (last == -2)      rd = '0;
      else if (last == -1) rd = ERRD;
      else                 rd = bus.s_rdata[last*32 +: 32];
      chk("model_m_nak",   {31'd0, bus.m_nak}, {31'd0, stall});
      chk("model_s_en",    {28'd0, bus.s_en}, {28'd0, en});
      chk("model_s_we",    {28'd0, bus.s_we}, {28'd0, we});
      chk("model_s_addr",  bus.s_addr, bus.m_addr);
      chk("model_s_wdata", bus.s_wdata, bus.m_wdata);
      chk("model_m_rdata", bus.m_rdata, rd);
      chk("model_err_irq", {31'd0, bus.err_irq}, {31'd0, e_irq});
      chk("model_err_addr", bus.err_addr, e_addr);
      chk("model_err_code", {30'd0, bus.err_code}, {30'd0, e_code});
      @(posedge clk);
      if (rstn) begin
        done = bus.m_stb && !stall;
        if (stall) begin
          stall_n   = (stall_n > 0 && sl == stall_slv) ? stall_n + 1 : 1;
          stall_slv = sl;
        end else begin
          stall_n = 0;
        end
        err = done && (sl < 0 || forced);
        if (done) last = err ? -1 : sl;
        if (err && (!e_irq || bus.err_clr)) begin
          e_irq  = 1'b1;
          e_addr = bus.m_addr;
          e_code = forced ? 2'b10 : 2'b01;
        end else if (bus.err_clr) begin
          e_irq = 1'b0; e_addr = '0; e_code = 2'b00;
        end
      end
    end
  end

  task automatic drive(input logic rst, input logic stb, input logic [3:0] we,
                       input logic [31:0] addr, input logic [3:0] nak, input logic clr);
    @(negedge clk);
    rstn        = rst;
    bus.m_stb   = stb;
    bus.m_we    = we;
    bus.m_addr  = addr;
    bus.m_wdata = ~addr;
    bus.s_nak   = nak;
    bus.err_clr = clr;
    #4;
  endtask

  initial begin : stimulus
    bus.m_stb   = 1'b0;
    bus.m_we    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.s_nak   = '0;
    bus.err_clr = 1'b0;
    bus.s_rdata = {32'h33333333, 32'h12345678, 32'h11111111, 32'h00000A0A};

    // Reset values
    drive(0, 0, 4'h0, 32'h0, 4'h0, 0);
    drive(0, 0, 4'h0, 32'h0, 4'h0, 0);
    chk("rst_m_nak", {31'd0, bus.m_nak}, 32'd0);
    chk("rst_m_rdata", bus.m_rdata, 32'd0);
    chk("rst_err_irq", {31'd0, bus.err_irq}, 32'd0);
    chk("rst_err_addr", bus.err_addr, 32'd0);
    chk("rst_err_code", {30'd0, bus.err_code}, 32'd0);

    // Zero-wait read of slave 2
    drive(1, 1, 4'h0, 32'hA000_0010, 4'h0, 0);
    chk("rd2_s_en", {28'd0, bus.s_en}, 32'h4);
    chk("rd2_m_nak", {31'd0, bus.m_nak}, 32'd0);
    drive(1, 0, 4'h0, 32'h0, 4'h0, 0);
    chk("rd2_m_rdata", bus.m_rdata, 32'h1234_5678);
    chk("rd2_s_en_off", {28'd0, bus.s_en}, 32'd0);

    // Write to slave 1 with three wait states
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 4'b0011, 32'h2000_0004, (k < 3) ? 4'b0010 : 4'b0000, 0);
      chk("wr1_m_nak", {31'd0, bus.m_nak}, (k < 3) ? 32'd1 : 32'd0);
      chk("wr1_s_we", {28'd0, bus.s_we}, 32'h3);
    end
    drive(1, 0, 4'h0, 32'h0, 4'h0, 0);
    chk("wr1_err_irq", {31'd0, bus.err_irq}, 32'd0);
    chk("wr1_m_rdata", bus.m_rdata, 32'h1111_1111);

    // Unmapped access
    drive(1, 1, 4'h0, 32'h7000_0000, 4'h0, 0);
    chk("unm_m_nak", {31'd0, bus.m_nak}, 32'd0);
    chk("unm_s_en", {28'd0, bus.s_en}, 32'd0);
    drive(1, 0, 4'h0, 32'h0, 4'h0, 0);
    chk("unm_m_rdata", bus.m_rdata, ERRD);
    chk("unm_err_irq", {31'd0, bus.err_irq}, 32'd1);
    chk("unm_err_addr", bus.err_addr, 32'h7000_0000);
    chk("unm_err_code", {30'd0, bus.err_code}, 32'd1);
    drive(1, 0, 4'h0, 32'h0, 4'h0, 1);
    drive(1, 0, 4'h0, 32'h0, 4'h0, 0);
    chk("clr_err_irq", {31'd0, bus.err_irq}, 32'd0);
    chk("clr_err_code", {30'd0, bus.err_code}, 32'd0);

    // Two timeouts on slave 3; the second must not overwrite the report
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 4'h0, 32'h3000_0100, 4'b1000, 0);
      chk("tmo1_m_nak", {31'd0, bus.m_nak}, (k < 4) ? 32'd1 : 32'd0);
      chk("tmo1_s_en", {28'd0, bus.s_en}, (k < 4) ? 32'h8 : 32'h0);
    end
    drive(1, 0, 4'h0, 32'h0, 4'b1000, 0);
    chk("tmo1_m_rdata", bus.m_rdata, ERRD);
    chk("tmo1_err_code", {30'd0, bus.err_code}, 32'd2);
    chk("tmo1_err_addr", bus.err_addr, 32'h3000_0100);
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 4'h0, 32'h3000_0200, 4'b1000, 0);
      chk("tmo2_m_nak", {31'd0, bus.m_nak}, (k < 4) ? 32'd1 : 32'd0);
    end

    // Back-to-back: slave 0 read straight after the forced completion
    drive(1, 1, 4'h0, 32'h1000_0000, 4'b1000, 0);
    chk("b2b_m_nak", {31'd0, bus.m_nak}, 32'd0);
    chk("b2b_s_en", {28'd0, bus.s_en}, 32'h1);
    chk("b2b_m_rdata_err", bus.m_rdata, ERRD);
    chk("tmo2_err_addr", bus.err_addr, 32'h3000_0100);
    chk("tmo2_err_code", {30'd0, bus.err_code}, 32'd2);
    drive(1, 0, 4'h0, 32'h0, 4'h0, 0);
    chk("b2b_m_rdata", bus.m_rdata, 32'h0000_0A0A);

    // Clear and new unmapped error in the same cycle: set wins
    drive(1, 1, 4'h0, 32'h5000_0008, 4'h0, 1);
    drive(1, 0, 4'h0, 32'h0, 4'h0, 0);
    chk("setwin_err_irq", {31'd0, bus.err_irq}, 32'd1);
    chk("setwin_err_addr", bus.err_addr, 32'h5000_0008);
    chk("setwin_err_code", {30'd0, bus.err_code}, 32'd1);

    // Strobe withdrawn mid-stall: no error
    drive(1, 0, 4'h0, 32'h0, 4'h0, 1);
    drive(1, 1, 4'h0, 32'h2000_0000, 4'b0010, 0);
    drive(1, 1, 4'h0, 32'h2000_0000, 4'b0010, 0);
    drive(1, 0, 4'h0, 32'h0, 4'b0010, 0);
    chk("drop_m_nak", {31'd0, bus.m_nak}, 32'd0);
    drive(1, 0, 4'h0, 32'h0, 4'h0, 0);
    chk("drop_err_irq", {31'd0, bus.err_irq}, 32'd0);

    // Slave changes while stalled: watchdog restarts on the new slave
    for (int k = 0; k < 7; k++) begin
      drive(1, 1, 4'h0, (k < 2) ? 32'h2000_0008 : 32'h3000_0300, 4'b1010, 0);
      chk("swap_m_nak", {31'd0, bus.m_nak}, (k < 6) ? 32'd1 : 32'd0);
    end
    drive(1, 0, 4'h0, 32'h0, 4'h0, 0);
    chk("swap_err_code", {30'd0, bus.err_code}, 32'd2);
    chk("swap_err_addr", bus.err_addr, 32'h3000_0300);

    // Reset asserted during a stall, then a clean access
    drive(1, 1, 4'h0, 32'h2000_0000, 4'b0010, 0);
    drive(1, 1, 4'h0, 32'h2000_0000, 4'b0010, 0);
    drive(0, 1, 4'h0, 32'h2000_0000, 4'b0010, 0);
    chk("rstmid_m_nak", {31'd0, bus.m_nak}, 32'd0);
    chk("rstmid_s_en", {28'd0, bus.s_en}, 32'd0);
    chk("rstmid_m_rdata", bus.m_rdata, 32'd0);
    chk("rstmid_err_irq", {31'd0, bus.err_irq}, 32'd0);
    chk("rstmid_err_addr", bus.err_addr, 32'd0);
    drive(1, 1, 4'h0, 32'h2000_0000, 4'h0, 0);
    chk("post_m_nak", {31'd0, bus.m_nak}, 32'd0);
    chk("post_s_en", {28'd0, bus.s_en}, 32'h2);
    drive(1, 0, 4'h0, 32'h0, 4'h0, 0);
    chk("post_m_rdata", bus.m_rdata, 32'h1111_1111);
    chk("post_err_irq", {31'd0, bus.err_irq}, 32'd0);

    drive(1, 0, 4'h0, 32'h0, 4'h0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
